// File: rtl/vscale_imm_encoder.sv
// Immediate encoder: packs an immediate into an RV32 instruction template, or
// expands a load-immediate into ADDI / LUI / LUI+ADDI words with valid/ready handshakes.
`timescale 1ns/1ps

module vscale_imm_encoder #(
    parameter int unsigned XPR_LEN        = 32,
    parameter int unsigned IMM_TYPE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      li,
    input  logic [IMM_TYPE_WIDTH-1:0] imm_type,
    input  logic [XPR_LEN-1:0]        base_inst,
    input  logic [XPR_LEN-1:0]        imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XPR_LEN-1:0]        out_inst,
    output logic                      out_err,
    output logic                      out_last
);

    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = IMM_TYPE_WIDTH'(0);
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = IMM_TYPE_WIDTH'(1);
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = IMM_TYPE_WIDTH'(2);
    localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = IMM_TYPE_WIDTH'(3);

    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LUI    = 7'h37;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LAST  = 2'd1,
        FIRST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XPR_LEN-1:0] inst_d;
    logic               err_d;
    logic               last_d;
    logic [11:0]        pend_imm_q, pend_imm_d;
    logic [4:0]         pend_rd_q, pend_rd_d;

    logic [XPR_LEN-1:0] field_inst;
    logic               field_err;
    logic               fits_12;
    logic               accept;
    logic [4:0]         rd;
    logic [19:0]        lui_hi;
    logic [XPR_LEN-1:0] li_addi_x0;
    logic [XPR_LEN-1:0] li_lui;
    logic [XPR_LEN-1:0] pend_addi;
    logic               li_two_word;

    assign rd      = base_inst[11:7];
    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);

    // Rounding the upper part by imm[11] compensates for ADDI sign-extending its low 12 bits.
    assign lui_hi      = imm[31:12] + 20'(imm[11]);
    assign li_lui      = {lui_hi, rd, OPC_LUI};
    assign li_addi_x0  = {imm[11:0], 5'd0, 3'b000, rd, OPC_OP_IMM};
    assign li_two_word = ~fits_12 & (|imm[11:0]);
    assign pend_addi   = {pend_imm_q, pend_rd_q, 3'b000, pend_rd_q, OPC_OP_IMM};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = reset_n & ((state_q == EMPTY) | ((state_q == LAST) & out_ready));
    assign accept    = in_valid & in_ready;

    // Field-mode encode: overwrite only the immediate bits of the template.
    always_comb begin
        field_inst = base_inst;
        field_err  = ~fits_12;
        case (imm_type)
            IMM_S: begin
                field_inst[31:25] = imm[11:5];
                field_inst[11:7]  = imm[4:0];
            end
            IMM_U: begin
                field_inst[31:12] = imm[31:12];
                field_err         = |imm[11:0];
            end
            IMM_J: begin
                field_inst[31]    = imm[20];
                field_inst[30:21] = imm[10:1];
                field_inst[20]    = imm[11];
                field_inst[19:12] = imm[19:12];
                field_err         = imm[0] | ~((&imm[31:20]) | ~(|imm[31:20]));
            end
            default: begin
                field_inst[31:20] = imm[11:0];
            end
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        inst_d     = out_inst;
        err_d      = out_err;
        last_d     = out_last;
        pend_imm_d = pend_imm_q;
        pend_rd_d  = pend_rd_q;

        case (state_q)
            FIRST: begin
                if (out_ready) begin
                    inst_d  = pend_addi;
                    err_d   = 1'b0;
                    last_d  = 1'b1;
                    state_d = LAST;
                end
            end
            LAST: begin
                if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            if (li) begin
                err_d = 1'b0;
                if (li_two_word) begin
                    inst_d     = li_lui;
                    last_d     = 1'b0;
                    pend_imm_d = imm[11:0];
                    pend_rd_d  = rd;
                    state_d    = FIRST;
                end else begin
                    inst_d  = fits_12 ? li_addi_x0 : li_lui;
                    last_d  = 1'b1;
                    state_d = LAST;
                end
            end else begin
                inst_d  = field_inst;
                err_d   = field_err;
                last_d  = 1'b1;
                state_d = LAST;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            out_inst   <= '0;
            out_err    <= 1'b0;
            out_last   <= 1'b0;
            pend_imm_q <= '0;
            pend_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_inst   <= inst_d;
            out_err    <= err_d;
            out_last   <= last_d;
            pend_imm_q <= pend_imm_d;
            pend_rd_q  <= pend_rd_d;
        end
    end

endmodule

// File: tb/tb_vscale_imm_encoder.sv
// Directed bench for vscale_imm_encoder: field encode, range errors, li expansion,
// back-pressure, back-to-back throughput and asynchronous reset mid-sequence.
`timescale 1ns/1ps

module tb_vscale_imm_encoder;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_U = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        li = 1'b0;
    logic [1:0]  imm_type = IMM_I;
    logic [31:0] base_inst = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;

    int checks = 0;
    int failures = 0;

    vscale_imm_encoder #(.XPR_LEN(32), .IMM_TYPE_WIDTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .li        (li),
        .imm_type  (imm_type),
        .base_inst (base_inst),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic l, input logic [1:0] t, input logic [31:0] b, input logic [31:0] m);
        in_valid  = 1'b1;
        li        = l;
        imm_type  = t;
        base_inst = b;
        imm       = m;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=00000000", out_inst); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", out_err); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        set_req(1'b0, IMM_I, 32'h00000013, 32'h00000001);
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_accept got=%b exp=0", out_valid); end
        in_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_field();
        logic [31:0] fb [10];
        logic [1:0]  ft [10];
        logic [31:0] fm [10];
        logic [31:0] fe [10];
        logic        fr [10];
        fb = '{32'h00000013, 32'h00000013, 32'hABCDE013, 32'h00002023, 32'h00002023,
               32'h00000037, 32'h00000037, 32'h0000006F, 32'h0000006F, 32'h0000006F};
        ft = '{IMM_I, IMM_I, IMM_I, IMM_S, IMM_S, IMM_U, IMM_U, IMM_J, IMM_J, IMM_J};
        fm = '{32'hFFFFFFFF, 32'h00000800, 32'h00000005, 32'hFFFFFFFC, 32'h00000800,
               32'h12345000, 32'h12345001, 32'h00000002, 32'h00000001, 32'hFFFFF800};
        fe = '{32'hFFF00013, 32'h80000013, 32'h005DE013, 32'hFE002E23, 32'h80002023,
               32'h12345037, 32'h12345037, 32'h0020006F, 32'h0000006F, 32'h801FF06F};
        fr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_req(1'b0, ft[k], fb[k], fm[k]);
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL field_valid[%0d] got=%b exp=1", k, out_valid); end
            checks++; if (out_inst !== fe[k]) begin failures++; $display("FAIL field_inst[%0d] got=%h exp=%h", k, out_inst, fe[k]); end
            checks++; if (out_err !== fr[k]) begin failures++; $display("FAIL field_err[%0d] got=%b exp=%b", k, out_err, fr[k]); end
            checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL field_last[%0d] got=%b exp=1", k, out_last); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL field_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_li();
        logic [31:0] sb [4];
        logic [31:0] sm [4];
        logic [31:0] se [4];
        out_ready = 1'b1;
        set_req(1'b1, IMM_U, 32'h00000280, 32'h12345FFF);
        tick();
        base_inst = 32'hFFFFFFFF;
        imm       = 32'h00000000;
        in_valid  = 1'b0;
        checks++; if (out_inst !== 32'h123462B7) begin failures++; $display("FAIL li_lui got=%h exp=123462b7", out_inst); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL li_lui_last got=%b exp=0", out_last); end
        checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL li_lui_err got=%b exp=0", out_err); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL li_first_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_inst !== 32'hFFF28293) begin failures++; $display("FAIL li_addi got=%h exp=fff28293", out_inst); end
        checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL li_addi_last got=%b exp=1", out_last); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL li_drain got=%b exp=0", out_valid); end

        sb = '{32'hFFFFF0FF, 32'hFFFFF0FF, 32'h00000080, 32'h00000080};
        sm = '{32'h00000064, 32'h00010000, 32'hFFFFF800, 32'h80000000};
        se = '{32'h06400093, 32'h000100B7, 32'h80000093, 32'h800000B7};
        for (int k = 0; k < 4; k++) begin
            set_req(1'b1, IMM_J, sb[k], sm[k]);
            tick();
            in_valid = 1'b0;
            checks++; if (out_inst !== se[k]) begin failures++; $display("FAIL li_short_inst[%0d] got=%h exp=%h", k, out_inst, se[k]); end
            checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL li_short_last[%0d] got=%b exp=1", k, out_last); end
            checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL li_short_err[%0d] got=%b exp=0", k, out_err); end
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL li_short_single[%0d] got=%b exp=0", k, out_valid); end
        end

        set_req(1'b1, IMM_I, 32'h00000080, 32'hFFFFF7FF);
        tick();
        in_valid = 1'b0;
        checks++; if (out_inst !== 32'hFFFFF0B7) begin failures++; $display("FAIL li_wrap_lui got=%h exp=fffff0b7", out_inst); end
        tick();
        checks++; if (out_inst !== 32'h7FF08093) begin failures++; $display("FAIL li_wrap_addi got=%h exp=7ff08093", out_inst); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_req(1'b0, IMM_I, 32'h00000013, 32'h00000005);
        tick();
        set_req(1'b0, IMM_I, 32'h00000013, 32'h00000006);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_inst !== 32'h00500013) begin failures++; $display("FAIL bp_hold_inst[%0d] got=%h exp=00500013", k, out_inst); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", k, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_inst !== 32'h00600013) begin failures++; $display("FAIL bp_next_inst got=%h exp=00600013", out_inst); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end

        set_req(1'b1, IMM_I, 32'h00000280, 32'h12345FFF);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (out_inst !== 32'h123462B7) begin failures++; $display("FAIL bp_first_inst[%0d] got=%h exp=123462b7", k, out_inst); end
            checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL bp_first_last[%0d] got=%b exp=0", k, out_last); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_first_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_inst !== 32'hFFF28293) begin failures++; $display("FAIL bp_first_addi got=%h exp=fff28293", out_inst); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] be [4];
        int words;
        be = '{32'h00100013, 32'h00200013, 32'h00300013, 32'h00400013};
        words = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req(1'b0, IMM_I, 32'h00000013, 32'(k + 1));
            tick();
            if (out_valid === 1'b1) words++;
            checks++; if (out_inst !== be[k]) begin failures++; $display("FAIL b2b_inst[%0d] got=%h exp=%h", k, out_inst, be[k]); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", k, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (words !== 4) begin failures++; $display("FAIL b2b_words got=%0d exp=4", words); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_li();
        out_ready = 1'b0;
        set_req(1'b1, IMM_I, 32'h00000280, 32'h12345FFF);
        tick();
        in_valid = 1'b0;
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_mid_first got=%b exp=0", out_last); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL rst_mid_inst got=%h exp=00000000", out_inst); end
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_no_addi[%0d] got=%b exp=0", k, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_field();
        test_li();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_li();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vscale_imm_encoder.md
VSCALE_IMM_ENCODER -- requirements
Module: vscale_imm_encoder

Interface
REQ-001: Parameter XPR_LEN, default 32, instruction and immediate width; only 32 is supported.
REQ-002: clk  input  1  rising-edge clock; sole clock of the block.
REQ-003: reset_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  request present.
REQ-005: in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-006: li  input  1  1 = load-immediate expansion; 0 = field encode.
REQ-007: imm_type  input  IMM_TYPE_WIDTH  immediate format, using IMM_I, IMM_S, IMM_U or IMM_J from the shared ctrl constants; ignored when li=1.
REQ-008: base_inst  input  32  template word; immediate bit positions are overwritten; in li mode only [11:7] (rd) is used.
REQ-009: imm  input  32  immediate value to encode.
REQ-010: out_valid  output  1  out_inst holds a word.
REQ-011: out_ready  input  1  consumer takes the word when out_valid && out_ready.
REQ-012: out_inst  output  32  encoded instruction.
REQ-013: out_err  output  1  imm is not representable in imm_type; the word is still emitted with truncated fields.
REQ-014: out_last  output  1  final word of the current request.

Function
REQ-015: In field mode, non-immediate bits SHALL pass from base_inst unchanged.
- I: inst[31:20]=imm[11:0].
- S: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0].
- U: inst[31:12]=imm[31:12].
- J: inst[31]=imm[20]; inst[30:21]=imm[10:1]; inst[20]=imm[11]; inst[19:12]=imm[19:12].
- Any other imm_type value encodes as I.
REQ-016: out_err SHALL be set when the immediate is not representable:
- I/S/default: imm[31:11] not all equal.
- U: imm[11:0]!=0.
- J: imm[0]=1 or imm[31:20] not all equal.
REQ-017: Li mode SHALL emit words from rd=base_inst[11:7], with out_err always 0:
- If imm[31:11] are all equal: one word, ADDI rd,x0,imm[11:0] (opcode 0x13, funct3 0).
- Otherwise: LUI rd,hi (opcode 0x37), where hi=(imm+32'h800)[31:12] and the addition wraps modulo 2^32.
- After LUI, ADDI rd,rd,imm[11:0] follows only when imm[11:0]!=0.
REQ-018: State machine states are EMPTY, LAST and FIRST.
- EMPTY: no word held.
- LAST: final word held.
- FIRST: LUI held, ADDI pending.
REQ-019: State transitions SHALL be:
- On accept: to FIRST for a two-word li; otherwise to LAST.
- FIRST with out_ready: load ADDI, go to LAST.
- LAST with out_ready: to EMPTY, or to the new request's state if accepted the same cycle.
REQ-020: in_ready SHALL equal (state==EMPTY) || (state==LAST && out_ready); it is 0 in FIRST; throughput is one request per cycle.
REQ-021: Latency: out_valid SHALL assert the cycle after acceptance; out_inst/out_err/out_last are registered outputs.
REQ-022: Output stability: while out_valid && !out_ready, the out_inst, out_err and out_last outputs SHALL remain stable and the state SHALL hold.
REQ-023: out_last SHALL be 1 in LAST and 0 in FIRST.
REQ-024: Input capture: imm[11:0] and rd SHALL be captured at acceptance; later input changes do not affect the pending ADDI.

Reset
REQ-025: While reset_n=0, the block SHALL be in state EMPTY with out_valid=0, out_inst=0, out_err=0, out_last=0, and in_ready=0.
REQ-026: Reset assertion SHALL take effect immediately without clk, including mid-sequence; a pending ADDI is discarded.
REQ-027: The first acceptance SHALL be possible on the first clk edge after reset_n deasserts.

Verification
REQ-028: Field I: base_inst=0x00000013, imm=0xFFFFFFFF, imm_type=IMM_I -> out_inst=0xFFF00013, out_err=0, out_last=1 one cycle later.
REQ-029: Range error: IMM_I, imm=0x00000800, base=0x00000013 -> out_inst=0x80000013, out_err=1; IMM_J, imm=0x00000002, base=0x0000006F -> out_inst=0x0020006F, out_err=0.
REQ-030: Li expansion: li=1, rd=5, imm=0x12345FFF, out_ready=1 -> 0x123462B7 (out_last=0) then 0xFFF28293 (out_last=1); in_ready=0 during the first word.
REQ-031: Li short forms: imm=0x00000064, rd=1 -> single 0x06400093; imm=0x00010000, rd=1 -> single LUI 0x000100B7.
REQ-032: Back-pressure: hold out_ready=0 for 3 cycles with a word held -> out_inst stable, in_ready=0; back-to-back requests with out_ready=1 -> one word per cycle, no loss.
REQ-033: Reset mid-li: assert reset_n=0 while the LUI is held -> out_valid drops without a clk edge; after release no ADDI appears.
